// File: rtl/pc_seq_ctrl_pkg.sv
// pc_ctrl_pkg: shared types and constants for the PC sequencer (PC_SEQ_CTRL_PERF_EN enables perf counters)
package pc_ctrl_pkg;
  typedef enum logic [1:0] {SEQ, BRANCH, JAL, JALR} pc_op_e;
  typedef enum logic [1:0] {BOOT, IDLE, WAIT_CMP, EMIT} pc_state_e;
  localparam logic [31:0] PC_INCR   = 32'd4;
  localparam logic [31:0] BOOT_ADDR = 32'h0000_0080;
  localparam logic [31:0] TRAP_ADDR = 32'h0000_0004;
  // Misaligned targets are replaced by the trap vector.
  function automatic logic [31:0] fix_target(input logic [31:0] t);
    return t[1] ? TRAP_ADDR : t;
  endfunction
endpackage

// File: rtl/pc_seq_ctrl_if.sv
// pc_seq_ctrl_if: Issue request, ALU compare, flush and IF handshake bundle
interface pc_seq_ctrl_if;
  import pc_ctrl_pkg::*;
  logic        req_valid_i;
  logic        req_ready_o;
  pc_op_e      req_op_i;
  logic [31:0] req_base_i;
  logic [31:0] req_offset_i;
  logic        cmp_valid_i;
  logic [31:0] cmp_result_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic        pc_valid_o;
  logic [31:0] pc_o;
  logic        pc_ready_i;
  logic [31:0] link_o;
  logic        redirect_o;
  logic        trap_o;
  modport slave (
    input  req_valid_i, req_op_i, req_base_i, req_offset_i, cmp_valid_i, cmp_result_i,
           flush_i, flush_pc_i, pc_ready_i,
    output req_ready_o, pc_valid_o, pc_o, link_o, redirect_o, trap_o
  );
  modport master (
    output req_valid_i, req_op_i, req_base_i, req_offset_i, cmp_valid_i, cmp_result_i,
           flush_i, flush_pc_i, pc_ready_i,
    input  req_ready_o, pc_valid_o, pc_o, link_o, redirect_o, trap_o
  );
endinterface

// File: rtl/pc_seq_ctrl_perf.sv
// pc_seq_perf: saturating branch/taken counters, built only with PC_SEQ_CTRL_PERF_EN
module pc_seq_perf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_branch,
  input  logic        i_taken,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_taken_cnt
);
  logic [31:0] r_branch, r_taken;
  // Count consumed compares and taken ones, sticking at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_branch <= '0;
      r_taken  <= '0;
    end else begin
      if (i_branch && ~&r_branch) r_branch <= r_branch + 32'd1;
      if (i_taken && ~&r_taken) r_taken <= r_taken + 32'd1;
    end
  end
  assign o_branch_cnt = r_branch;
  assign o_taken_cnt  = r_taken;
endmodule

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: next-PC sequencer between Issue, ALU compare and IF (PC_SEQ_CTRL_PERF_EN adds perf counters)
module pc_seq_ctrl
  import pc_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  pc_seq_ctrl_if.slave bus
`ifdef PC_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] perf_branch_o,
  output logic [31:0] perf_taken_o
`endif
);
  pc_state_e   r_state;
  logic [31:0] r_pc, r_next, r_offset, r_link;
  logic        r_req_ready, r_pc_valid, r_redirect, r_trap;
  logic [31:0] w_seq, w_req_tgt, w_cmp_tgt;
  logic        w_unused;
  assign w_seq     = r_pc + PC_INCR;
  assign w_req_tgt = bus.req_op_i == JALR ? (bus.req_base_i + bus.req_offset_i) & ~32'h1 :
                     bus.req_op_i == JAL  ? r_pc + bus.req_offset_i : w_seq;
  assign w_cmp_tgt = bus.cmp_result_i[0] ? r_pc + r_offset : w_seq;
  assign w_unused  = ^bus.cmp_result_i[31:1];
  // Sequencer FSM; flush overrides every state and all outputs are registered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= BOOT;
      r_pc        <= BOOT_ADDR;
      r_next      <= BOOT_ADDR;
      r_offset    <= '0;
      r_link      <= '0;
      r_req_ready <= 1'b0;
      r_pc_valid  <= 1'b0;
      r_redirect  <= 1'b0;
      r_trap      <= 1'b0;
    end else if (bus.flush_i) begin
      r_state     <= EMIT;
      r_next      <= bus.flush_pc_i;
      r_redirect  <= 1'b1;
      r_trap      <= 1'b0;
      r_pc_valid  <= 1'b1;
      r_req_ready <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= EMIT;
          r_next     <= BOOT_ADDR;
          r_redirect <= 1'b1;
          r_trap     <= 1'b0;
          r_pc_valid <= 1'b1;
        end
        IDLE: if (bus.req_valid_i) begin
          r_req_ready <= 1'b0;
          r_link      <= w_seq;
          r_offset    <= bus.req_offset_i;
          if (bus.req_op_i == BRANCH) r_state <= WAIT_CMP;
          else begin
            r_state    <= EMIT;
            r_pc_valid <= 1'b1;
            r_next     <= fix_target(w_req_tgt);
            r_trap     <= w_req_tgt[1];
            r_redirect <= bus.req_op_i != SEQ || w_req_tgt[1];
          end
        end
        WAIT_CMP: if (bus.cmp_valid_i) begin
          r_state    <= EMIT;
          r_pc_valid <= 1'b1;
          r_next     <= fix_target(w_cmp_tgt);
          r_trap     <= w_cmp_tgt[1];
          r_redirect <= bus.cmp_result_i[0] || w_cmp_tgt[1];
        end
        EMIT: if (bus.pc_ready_i) begin
          r_pc        <= r_next;
          r_state     <= IDLE;
          r_pc_valid  <= 1'b0;
          r_req_ready <= 1'b1;
          r_redirect  <= 1'b0;
          r_trap      <= 1'b0;
        end
      endcase
    end
  end
  assign bus.req_ready_o = r_req_ready;
  assign bus.pc_valid_o  = r_pc_valid;
  assign bus.pc_o        = r_next;
  assign bus.link_o      = r_link;
  assign bus.redirect_o  = r_redirect;
  assign bus.trap_o      = r_trap;
`ifdef PC_SEQ_CTRL_PERF_EN
  logic w_cmp_take;
  assign w_cmp_take = r_state == WAIT_CMP && bus.cmp_valid_i && !bus.flush_i;
  pc_seq_perf u_perf (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .i_branch     (w_cmp_take),
    .i_taken      (w_cmp_take && bus.cmp_result_i[0]),
    .o_branch_cnt (perf_branch_o),
    .o_taken_cnt  (perf_taken_o)
  );
`endif
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb_pc_seq_ctrl: vector table plus corner sequences with a scoreboard on the IF handshake
module tb_pc_seq_ctrl;
  import pc_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [33:0] exp_q[$];
  pc_seq_ctrl_if bus();
`ifdef PC_SEQ_CTRL_PERF_EN
  logic [31:0] perf_branch, perf_taken;
`endif
  pc_seq_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef PC_SEQ_CTRL_PERF_EN
    ,
    .perf_branch_o (perf_branch),
    .perf_taken_o  (perf_taken)
`endif
  );
  always #5 clk = ~clk;

  typedef struct {
    pc_op_e      op;
    logic [31:0] base;
    logic [31:0] off;
    logic        cmp;
    int          dly;
    logic [31:0] pc;
    logic        redir;
    logic        trap;
    logic [31:0] link;
  } vec_t;
  vec_t tv[12];

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted PC must match the oldest expected {pc, redirect, trap}.
  always @(negedge clk) begin
    if (!rst && bus.pc_valid_o && bus.pc_ready_i && !bus.flush_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL emit: unexpected pc %h", bus.pc_o);
      end else chk("emit", {bus.pc_o, bus.redirect_o, bus.trap_o}, exp_q.pop_front());
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready_o && exp_q.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: pending %0d want 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic send_req(input pc_op_e op, input logic [31:0] base, input logic [31:0] off,
                          input logic [31:0] link);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready_o) begin
      checks++;
      errors++;
      $display("FAIL req_ready_timeout: got 0 want 1");
      return;
    end
    bus.req_valid_i  = 1'b1;
    bus.req_op_i     = op;
    bus.req_base_i   = base;
    bus.req_offset_i = off;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    chk("link", {2'b0, bus.link_o}, {2'b0, link});
  endtask

  task automatic send_cmp(input logic res, input int dly);
    logic [31:0] r;
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    r = $urandom();
    r[0] = res;
    bus.cmp_valid_i  = 1'b1;
    bus.cmp_result_i = r;
    @(posedge clk);
    #1 bus.cmp_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    tv[0]  = '{SEQ,    32'h0,    32'h0,         1'b0, 0, 32'h84,        1'b0, 1'b0, 32'h84};
    tv[1]  = '{JAL,    32'h0,    32'h7C,        1'b0, 0, 32'h100,       1'b1, 1'b0, 32'h88};
    tv[2]  = '{BRANCH, 32'h0,    32'hFFFF_FFF0, 1'b1, 0, 32'hF0,        1'b1, 1'b0, 32'h104};
    tv[3]  = '{JAL,    32'h0,    32'h10,        1'b0, 0, 32'h100,       1'b1, 1'b0, 32'hF4};
    tv[4]  = '{BRANCH, 32'h0,    32'hFFFF_FFF0, 1'b0, 1, 32'h104,       1'b0, 1'b0, 32'h104};
    tv[5]  = '{JALR,   32'h2001, 32'h0,         1'b0, 0, 32'h2000,      1'b1, 1'b0, 32'h108};
    tv[6]  = '{JALR,   32'h2002, 32'h0,         1'b0, 0, 32'h4,         1'b1, 1'b1, 32'h2004};
    tv[7]  = '{BRANCH, 32'h0,    32'h2,         1'b1, 0, 32'h4,         1'b1, 1'b1, 32'h8};
    tv[8]  = '{JALR,   32'h1001, 32'hFFFF_FFFF, 1'b0, 0, 32'h1000,      1'b1, 1'b0, 32'h8};
    tv[9]  = '{JAL,    32'h0,    32'hFFFF_EFFC, 1'b0, 0, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h1004};
    tv[10] = '{SEQ,    32'h0,    32'h0,         1'b0, 0, 32'h0,         1'b0, 1'b0, 32'h0};
    tv[11] = '{BRANCH, 32'h0,    32'h20,        1'b1, 3, 32'h20,        1'b1, 1'b0, 32'h4};
    bus.req_valid_i  = 1'b0;
    bus.req_op_i     = SEQ;
    bus.req_base_i   = '0;
    bus.req_offset_i = '0;
    bus.cmp_valid_i  = 1'b0;
    bus.cmp_result_i = '0;
    bus.flush_i      = 1'b0;
    bus.flush_pc_i   = '0;
    bus.pc_ready_i   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", {2'b0, bus.pc_o}, {2'b0, BOOT_ADDR});
    chk("rst_flags", {30'b0, bus.pc_valid_o, bus.req_ready_o, bus.redirect_o, bus.trap_o}, '0);
    chk("rst_link", {2'b0, bus.link_o}, '0);
    exp_q.push_back({BOOT_ADDR, 1'b1, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back({tv[i].pc, tv[i].redir, tv[i].trap});
      send_req(tv[i].op, tv[i].base, tv[i].off, tv[i].link);
      if (tv[i].op == BRANCH) send_cmp(tv[i].cmp, tv[i].dly);
      wait_idle();
    end
`ifdef PC_SEQ_CTRL_PERF_EN
    chk("perf_branch", {2'b0, perf_branch}, {2'b0, 32'd4});
    chk("perf_taken", {2'b0, perf_taken}, {2'b0, 32'd3});
`endif
    bus.pc_ready_i = 1'b0;
    exp_q.push_back({32'h24, 1'b0, 1'b0});
    send_req(SEQ, 32'h0, 32'h0, 32'h24);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pc", {bus.pc_o, bus.redirect_o, bus.trap_o}, {32'h24, 1'b0, 1'b0});
      chk("hold_hs", {32'b0, bus.pc_valid_o, bus.req_ready_o}, {32'b0, 1'b1, 1'b0});
    end
    bus.pc_ready_i = 1'b1;
    wait_idle();
    send_req(BRANCH, 32'h0, 32'h100, 32'h28);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h400;
    exp_q.push_back({32'h400, 1'b1, 1'b0});
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    bus.cmp_valid_i  = 1'b1;
    bus.cmp_result_i = 32'h1;
    @(posedge clk);
    #1 bus.cmp_valid_i = 1'b0;
    wait_idle();
    exp_q.push_back({32'h404, 1'b0, 1'b0});
    send_req(SEQ, 32'h0, 32'h0, 32'h404);
    wait_idle();
`ifdef PC_SEQ_CTRL_PERF_EN
    chk("perf_flushed", {2'b0, perf_branch}, {2'b0, 32'd4});
`endif
    bus.pc_ready_i = 1'b0;
    send_req(JAL, 32'h0, 32'h10, 32'h408);
    chk("hold_jal", {bus.pc_o, bus.redirect_o, bus.trap_o}, {32'h414, 1'b1, 1'b0});
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h802;
    bus.pc_ready_i = 1'b1;
    exp_q.push_back({32'h802, 1'b1, 1'b0});
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    wait_idle();
    exp_q.push_back({TRAP_ADDR, 1'b1, 1'b1});
    send_req(SEQ, 32'h0, 32'h0, 32'h806);
    wait_idle();
    send_req(BRANCH, 32'h0, 32'h0, 32'h8);
    #3 rst = 1'b1;
    #1;
    chk("arst_pc", {2'b0, bus.pc_o}, {2'b0, BOOT_ADDR});
    chk("arst_flags", {30'b0, bus.pc_valid_o, bus.req_ready_o, bus.redirect_o, bus.trap_o}, '0);
    chk("arst_link", {2'b0, bus.link_o}, '0);
`ifdef PC_SEQ_CTRL_PERF_EN
    chk("arst_perf", {2'b0, perf_branch}, '0);
`endif
    exp_q.delete();
    @(posedge clk);
    #1 bus.flush_i = 1'b1;
    bus.flush_pc_i = 32'h300;
    exp_q.push_back({32'h300, 1'b1, 1'b0});
    rst = 1'b0;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    wait_idle();
    exp_q.push_back({32'h304, 1'b0, 1'b0});
    send_req(SEQ, 32'h0, 32'h0, 32'h304);
    wait_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_seq_ctrl.md
# pc_seq_ctrl

Sequencer for program-counter generation. Owns the architectural PC register and accepts one control-flow request at a time from Issue: sequential, branch, JAL or JALR. For branches it waits for the ALU compare boolean, then computes the next PC. It presents that PC to IF over a valid/ready handshake. It sits between Issue, the ALU compare output and IF, and sequences the next-PC adder path.

## Interface
- BOOT_ADDR, 32'h0000_0080, PC presented after reset.
- TRAP_ADDR, 32'h0000_0004, PC substituted for any misaligned target.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  Issue request valid.
- req_ready_o  out  1  request accepted this cycle when both are high.
- req_op_i  in  2  pc_op_e: SEQ=0, BRANCH=1, JAL=2, JALR=3.
- req_base_i  in  32  JALR base register value; ignored otherwise.
- req_offset_i  in  32  sign-extended immediate.
- cmp_valid_i  in  1  ALU compare result valid.
- cmp_result_i  in  32  ALU compare result; bit 0 = condition true.
- flush_i  in  1  external redirect, for example an exception.
- flush_pc_i  in  32  redirect target.
- pc_valid_o  out  1  next PC valid to IF.
- pc_o  out  32  next PC.
- pc_ready_i  in  1  IF accepts pc_o.
- link_o  out  32  pc_q+4, registered at request acceptance; rd value for JAL/JALR.
- redirect_o  out  1  the PC in flight is non-sequential: taken branch, jump, flush or trap.
- trap_o  out  1  the PC in flight is TRAP_ADDR due to misalignment.

## Operation
- States (pc_state_e): BOOT, IDLE, WAIT_CMP, EMIT.
- BOOT: reset state. Next state is EMIT with next_q=BOOT_ADDR and redirect=1.
- IDLE: req_ready_o=1. On acceptance, latch the op, compute the target, and set link_o=pc_q+4.
  - SEQ, JAL, JALR go to EMIT.
  - BRANCH goes to WAIT_CMP.
- WAIT_CMP: hold until cmp_valid_i.
  - If cmp_result_i[0]=1, target = pc_q+offset.
  - Otherwise target = pc_q+4.
  - Then go to EMIT.
  - cmp_valid_i seen in any other state is ignored.
- Target arithmetic: 32-bit, modulo 2^32; wrap-around is silent.
  - SEQ: pc_q+4.
  - JAL: pc_q+offset.
  - JALR: (base+offset) & ~32'h1.
- Misalignment: if target[1]=1, next_q=TRAP_ADDR and trap=1. redirect is also set.
- EMIT: pc_valid_o=1, pc_o=next_q. On pc_ready_i: pc_q<=next_q, then go to IDLE.
- Flush has highest priority, in every state including BOOT. Any in-flight request or compare is discarded. flush_pc_i is not alignment-checked.
  - next_q<=flush_pc_i.
  - redirect=1, trap=0.
  - State goes to EMIT.
- A flush arriving in the same cycle as pc_ready_i wins; pc_q is not updated.
- Reset values:
  - state=BOOT, pc_q=BOOT_ADDR, next_q=BOOT_ADDR, link_o=0.
  - req_ready_o=0, pc_valid_o=0, redirect_o=0, trap_o=0.
  - pc_o=BOOT_ADDR.

## Timing
- Request handshake, sequential/jump ops: acceptance in cycle N gives pc_valid_o in N+1.
- Branch: cmp_valid_i in cycle M gives pc_valid_o in M+1. cmp_valid_i may arrive in the same cycle the state becomes WAIT_CMP.
- Holding rule: pc_o, redirect_o and trap_o are stable while pc_valid_o=1 and pc_ready_i=0, unless flush_i is asserted.
- Throughput: at most one request per 2 cycles (IDLE, EMIT).
- Reset mid-operation: asynchronous return to BOOT. After deassertion, BOOT_ADDR appears one cycle later.

## Configuration
- PC_SEQ_CTRL_PERF_EN defined: two 32-bit saturating counters are instantiated.
  - perf_branch_o counts branch compares consumed.
  - perf_taken_o counts taken branches.
  - Both reset to 0 and are exposed as outputs.
- Undefined: the counters and both ports are absent. Function is otherwise identical.

## Structure
- pc_ctrl_pkg holds:
  - pc_op_e and pc_state_e.
  - PC_INCR=32'd4.
  - Default BOOT_ADDR and TRAP_ADDR constants.
- One sub-module, pc_seq_perf, holds the counters; it is instantiated only under the macro.
- Target adder logic stays inline.

## Test plan
- Reset release: pc_valid_o=1 with pc_o=32'h80 and redirect_o=1. Accept, then SEQ gives pc_o=32'h84 and redirect_o=0.
- Branch at pc_q=32'h100, offset=32'hFFFF_FFF0:
  - cmp_result_i=1 gives pc_o=32'hF0 and redirect_o=1.
  - cmp_result_i=0 gives pc_o=32'h104.
- JALR base=32'h2001, offset=0 gives pc_o=32'h2000. Base=32'h2002 gives pc_o=TRAP_ADDR and trap_o=1.
- Backpressure: hold pc_ready_i=0 for 5 cycles. pc_o stays stable and req_ready_o=0 throughout.
- flush_i with flush_pc_i=32'h400 while in WAIT_CMP, then a late cmp_valid_i: pc_o=32'h400 and the late compare is ignored.
- SEQ at pc_q=32'hFFFF_FFFC gives pc_o=32'h0. With the macro defined, 3 branches with 2 taken give perf_branch_o=3 and perf_taken_o=2.
